// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and memory (slave).
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif

interface instr_fetch_unit_if;
  logic                       mem_req_o;
  logic [`MEM_ADDR_WIDTH-1:0] mem_addr_o;
  logic                       mem_gnt_i;
  logic                       mem_rvalid_i;
  logic [31:0]                mem_rdata_i;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Credit-limited instruction fetch unit: PC handshake -> memory request -> in-order buffer -> decode.
// Optional FETCH_MISALIGN_CHECK_EN aligns requests and tags each entry with a misalign bit.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif

module instr_fetch_unit #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [`MEM_ADDR_WIDTH-1:0] pc_addr_i,
  input  logic                       pc_valid_i,
  output logic                       pc_ready_o,
  input  logic                       flush_i,
  instr_fetch_unit_if.master         mem,
  output logic                       instr_valid_o,
  input  logic                       instr_ready_i,
  output logic [31:0]                instr_o,
  output logic [`MEM_ADDR_WIDTH-1:0] instr_addr_o,
  output logic                       instr_misalign_o
);

  localparam int AW = `MEM_ADDR_WIDTH;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {S_IDLE, S_WAIT_GNT} state_t;

  state_t          r_state, w_state_next;
  logic [CW-1:0]   r_outstanding, r_count, w_out_next;
  logic [7:0]      r_discard, w_discard_dec;
  logic [PW-1:0]   r_rd_ptr, r_wr_ptr, r_ga_ptr;
  logic [AW-1:0]   r_addr, w_addr_in;
  logic [CW:0]     w_inflight;
  logic            w_pending, w_credit, w_hs, w_gnt_acc;
  logic            w_rv_acc, w_rv_drop, w_push, w_pop;
  logic [31:0]     r_data_mem [DEPTH];
  logic [AW-1:0]   r_addr_mem [DEPTH];

  assign w_pending  = (r_state == S_WAIT_GNT);
  assign w_inflight = {1'b0, r_outstanding} + {1'b0, r_count} + {{CW{1'b0}}, w_pending};
  assign w_credit   = int'(w_inflight) < DEPTH;
  assign pc_ready_o = !rst && !flush_i && w_credit && (!w_pending || mem.mem_gnt_i);
  assign w_hs       = pc_valid_i && pc_ready_o;
  assign w_gnt_acc  = w_pending && mem.mem_gnt_i;

  // Beats with no matching live grant (discarded, or stale after reset) are never stored.
  assign w_rv_drop  = mem.mem_rvalid_i && (r_discard != '0);
  assign w_rv_acc   = mem.mem_rvalid_i && (r_discard == '0) && (r_outstanding != '0);
  assign w_push     = w_rv_acc && !flush_i;
  assign w_pop      = instr_valid_o && instr_ready_i && !flush_i;

  assign w_out_next    = r_outstanding + CW'(w_gnt_acc) - CW'(w_rv_acc);
  assign w_discard_dec = r_discard - 8'(w_rv_drop);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_state_next  = r_state;
    mem.mem_req_o = 1'b0;
    case (r_state)
      S_IDLE:     if (w_hs) w_state_next = S_WAIT_GNT;
      S_WAIT_GNT: begin
        mem.mem_req_o = 1'b1;
        if (mem.mem_gnt_i && !w_hs) w_state_next = S_IDLE;
      end
      default:    w_state_next = S_IDLE;
    endcase
    if (flush_i) w_state_next = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_ga_ptr      <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_hs) r_addr <= w_addr_in;
      if (flush_i) begin
        r_outstanding <= '0;
        r_discard     <= w_discard_dec + 8'(w_out_next);
        r_count       <= '0;
        r_rd_ptr      <= '0;
        r_wr_ptr      <= '0;
        r_ga_ptr      <= '0;
      end else begin
        r_outstanding <= w_out_next;
        r_discard     <= w_discard_dec;
        r_count       <= r_count + CW'(w_push) - CW'(w_pop);
        if (w_push)    r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_gnt_acc) r_ga_ptr <= r_ga_ptr + 1'b1;
      end
    end
  end

  // NOTE: buffer storage is not reset; entries are only visible while r_count says they are valid.
  // The address slot is claimed at grant time; in-order responses fill the same slot later.
  always_ff @(posedge clk) begin
    if (w_gnt_acc) r_addr_mem[r_ga_ptr] <= r_addr;
    if (w_push)    r_data_mem[r_wr_ptr] <= mem.mem_rdata_i;
  end

  assign mem.mem_addr_o = r_addr;
  assign instr_valid_o  = (r_count != '0);
  assign instr_o        = instr_valid_o ? r_data_mem[r_rd_ptr] : '0;
  assign instr_addr_o   = instr_valid_o ? r_addr_mem[r_rd_ptr] : '0;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_mis;
  logic r_mis_mem [DEPTH];

  assign w_addr_in = {pc_addr_i[AW-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst)       r_mis <= 1'b0;
    else if (w_hs) r_mis <= (pc_addr_i[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (w_gnt_acc) r_mis_mem[r_ga_ptr] <= r_mis;
  end

  assign instr_misalign_o = instr_valid_o && r_mis_mem[r_rd_ptr];
`else
  assign w_addr_in        = pc_addr_i;
  assign instr_misalign_o = 1'b0;
`endif

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 2, which sets the instruction buffer entries and the maximum outstanding plus buffered fetches (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port pc_addr_i  input  `MEM_ADDR_WIDTH  fetch address from program counter.
REQ-005 SHALL have port pc_valid_i  input  1  pc_addr_i valid.
REQ-006 SHALL have port pc_ready_o  output  1  address accepted this cycle when high with pc_valid_i.
REQ-007 SHALL have port flush_i  input  1  branch taken; discard all in-flight and buffered fetches.
REQ-008 SHALL have port mem_req_o  output  1  instruction memory request.
REQ-009 SHALL have port mem_addr_o  output  `MEM_ADDR_WIDTH  request address.
REQ-010 SHALL have port mem_gnt_i  input  1  request granted.
REQ-011 SHALL have port mem_rvalid_i  input  1  read data valid, one per grant, in order, at least one cycle after the grant.
REQ-012 SHALL have port mem_rdata_i  input  32  instruction word.
REQ-013 SHALL have port instr_valid_o  output  1  buffer head valid.
REQ-014 SHALL have port instr_ready_i  input  1  decode consumes head.
REQ-015 SHALL have port instr_o  output  32  head instruction.
REQ-016 SHALL have port instr_addr_o  output  `MEM_ADDR_WIDTH  head instruction address.
REQ-017 SHALL have port instr_misalign_o  output  1  head fetched from misaligned address (see Configuration).

Function
REQ-018 SHALL implement FSM IDLE/WAIT_GNT: IDLE->WAIT_GNT on PC handshake; WAIT_GNT->IDLE on gnt without a new handshake; WAIT_GNT stays on gnt plus a new handshake.
REQ-019 SHALL drive pc_ready_o = credit available AND (IDLE OR mem_gnt_i), where credit = outstanding + buffered + pending request < DEPTH.
REQ-020 SHALL register the handshake address: mem_req_o high and mem_addr_o valid the cycle after the handshake.
REQ-021 SHALL hold mem_req_o and mem_addr_o stable until mem_gnt_i, except on flush.
REQ-022 SHALL store each rvalid beat with its address in the buffer; instr_valid_o rises the cycle after mem_rvalid_i.
REQ-023 SHALL pop the head on instr_valid_o AND instr_ready_i; push and pop in the same cycle keep the occupancy constant.
REQ-024 SHALL not overflow: a full buffer with responses still outstanding is impossible by the credit rule; pointers wrap modulo DEPTH.
REQ-025 SHALL, on flush_i: empty the buffer, deassert mem_req_o the next cycle, go IDLE, and load a discard counter with the granted-but-unanswered count.
REQ-026 SHALL drop rvalid beats while the discard counter is nonzero, decrementing it by one per beat; a flush during discard adds the new outstanding count.
REQ-027 SHALL give flush_i priority over a same-cycle PC handshake (address dropped, pc_ready_o low) and over a same-cycle pop.
REQ-028 SHALL treat a grant in the flush cycle as outstanding and discard its response.

Reset
REQ-029 SHALL, while rst is high, reset the FSM to IDLE, zero counters and pointers, and drive mem_req_o=0, pc_ready_o=0, instr_valid_o=0, instr_misalign_o=0, mem_addr_o=0, instr_o=0, instr_addr_o=0.
REQ-030 SHALL, on reset mid-transaction, abandon any outstanding response; responses arriving after reset are not recorded.

Configuration
REQ-031 SHALL compile the misalignment check when FETCH_MISALIGN_CHECK_EN is defined: mem_addr_o[1:0] is forced to 00, a per-fetch misalign bit (pc_addr_i[1:0]!=0) travels with the request, and instr_misalign_o reports it with the entry.
REQ-032 SHALL, without FETCH_MISALIGN_CHECK_EN, pass the address unmodified and tie instr_misalign_o to 0.

Verification
REQ-033 SHALL pass: handshake 0x00 with gnt the same cycle, rvalid 2 cycles later with data 0x00000013 -> instr_valid_o=1, instr_o=0x00000013, instr_addr_o=0x00.
REQ-034 SHALL pass: DEPTH=2, instr_ready_i=0, handshakes 0x00/0x04/0x08 -> third stalls, pc_ready_o=0 until one pop.
REQ-035 SHALL pass: mem_gnt_i held 0 for 3 cycles -> mem_addr_o stays 0x10 and mem_req_o stays 1 throughout.
REQ-036 SHALL pass: two granted requests then flush_i, two rvalid beats, then handshake 0x40 -> beats dropped and first instr_addr_o=0x40.
REQ-037 SHALL pass: with the macro, handshake 0x06 -> mem_addr_o=0x04, instr_misalign_o=1; without the macro -> mem_addr_o=0x06, instr_misalign_o=0.
REQ-038 SHALL pass: rst asserted with one request outstanding -> next-cycle outputs equal reset values and a late rvalid is not recorded.
